// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchronizer, tick divider, start/data/parity/stop FSM,
// and a one-deep output holding register with a valid/ready handshake.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int CLK_DIV    = 27,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = 4;
  localparam logic [DW-1:0] DIV_M1  = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DLAST   = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] SLAST   = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t state_q, state_d;

  logic                 sync1, rx_s;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q, ferr_q;

  logic div_rst, tcnt_clr, tcnt_inc, bcnt_clr, shift_en, par_smp, stop_smp, done;
  logic ferr_fin, perr_fin;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // Free-running tick divider, re-phased to the detected start edge.
  assign tick = (div_cnt == DIV_M1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                div_cnt <= '0;
    else if (div_rst || tick)  div_cnt <= '0;
    else                       div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    div_rst  = 1'b0;
    tcnt_clr = 1'b0;
    tcnt_inc = 1'b0;
    bcnt_clr = 1'b0;
    shift_en = 1'b0;
    par_smp  = 1'b0;
    stop_smp = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d  = START;
          div_rst  = 1'b1;
          tcnt_clr = 1'b1;
          bcnt_clr = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (tcnt == HALF_M1) begin
            tcnt_clr = 1'b1;
            state_d  = rx_s ? IDLE : DATA;
          end else tcnt_inc = 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          if (tcnt == FULL_M1) begin
            tcnt_clr = 1'b1;
            shift_en = 1'b1;
            if (bcnt == DLAST) begin
              bcnt_clr = 1'b1;
              state_d  = (PARITY_EN != 0) ? PARITY : STOP;
            end
          end else tcnt_inc = 1'b1;
        end
      end
      PARITY: begin
        if (tick) begin
          if (tcnt == FULL_M1) begin
            tcnt_clr = 1'b1;
            par_smp  = 1'b1;
            state_d  = STOP;
          end else tcnt_inc = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (tcnt == FULL_M1) begin
            tcnt_clr = 1'b1;
            stop_smp = 1'b1;
            if (bcnt == SLAST) begin
              bcnt_clr = 1'b1;
              done     = 1'b1;
              state_d  = IDLE;
            end
          end else tcnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
      bcnt <= '0;
    end else begin
      if (tcnt_clr)      tcnt <= '0;
      else if (tcnt_inc) tcnt <= tcnt + 1'b1;
      if (bcnt_clr)                  bcnt <= '0;
      else if (shift_en || stop_smp) bcnt <= bcnt + 1'b1;
    end
  end

  // Per-frame datapath; error accumulators are cleared at each start detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg  <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (div_rst) begin
        perr_q <= 1'b0;
        ferr_q <= 1'b0;
      end
      if (shift_en) shreg  <= {rx_s, shreg[DATA_BITS-1:1]};
      if (par_smp)  perr_q <= ((^shreg) ^ rx_s) != 1'(PARITY_ODD);
      if (stop_smp) ferr_q <= ferr_q | ~rx_s;
    end
  end

  // The last stop sample is folded in combinationally so completion needs no extra cycle.
  assign ferr_fin = ferr_q | ~rx_s;
  assign perr_fin = (PARITY_EN != 0) ? perr_q : 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          data_out   <= shreg;
          frame_err  <= ferr_fin;
          parity_err <= perr_fin;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: three instances (8N1, 8E1, 7N2), 32 clk per bit.
module tb_uart_rx_os;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic rx0, rx1, rx2, r0, r1, r2;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic v0, v1, v2, fe0, fe1, fe2, pe0, pe1, pe2, ov0, ov1, ov2;

  uart_rx_os #(.CLK_DIV(2)) u0 (
    .clk(clk), .reset(reset), .rx(rx0), .data_out(d0), .valid(v0), .ready(r0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0));

  uart_rx_os #(.CLK_DIV(2), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(reset), .rx(rx1), .data_out(d1), .valid(v1), .ready(r1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1));

  uart_rx_os #(.CLK_DIV(2), .DATA_BITS(7), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .rx(rx2), .data_out(d2), .valid(v2), .ready(r2),
    .frame_err(fe2), .parity_err(pe2), .overrun(ov2));

  int checks = 0;
  int errors = 0;

  // Accepted-frame and overrun monitors (sampled on the falling edge).
  int acc0 = 0, acc1 = 0, acc2 = 0, ovc0 = 0, ovc2 = 0;
  logic [7:0] ld0, ld1;
  logic [6:0] ld2;
  logic lfe0, lpe0, lfe1, lpe1, lfe2;

  always @(negedge clk) begin
    if (v0 && r0) begin acc0++; ld0 = d0; lfe0 = fe0; lpe0 = pe0; end
    if (v1 && r1) begin acc1++; ld1 = d1; lfe1 = fe1; lpe1 = pe1; end
    if (v2 && r2) begin acc2++; ld2 = d2; lfe2 = fe2; end
    if (ov0) ovc0++;
    if (ov2) ovc2++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bitx(input int u, input logic v);
    case (u)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
    repeat (32) @(posedge clk);
  endtask

  task automatic send(input int u, input logic [7:0] d, input int nb, input int pbit,
                      input logic s1, input logic s2, input int ns);
    bitx(u, 1'b0);
    for (int i = 0; i < nb; i++) bitx(u, d[i]);
    if (pbit >= 0) bitx(u, pbit[0]);
    bitx(u, s1);
    if (ns == 2) bitx(u, s2);
  endtask

  int n, m;

  initial begin
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid0", 32'(v0), 32'd0);
    chk("rst_data0", 32'(d0), 32'd0);
    chk("rst_flags0", 32'({fe0, pe0, ov0}), 32'd0);
    chk("rst_valid2", 32'(v2), 32'd0);
    reset = 1'b1;
    repeat (40) @(posedge clk);

    // 0xA5, 8N1
    n = acc0;
    send(0, 8'hA5, 8, -1, 1'b1, 1'b1, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("a5_count", 32'(acc0 - n), 32'd1);
    chk("a5_data", 32'(ld0), 32'hA5);
    chk("a5_fe", 32'(lfe0), 32'd0);
    chk("a5_pe", 32'(lpe0), 32'd0);
    chk("a5_valid_cleared", 32'(v0), 32'd0);

    // 6-clk glitch is rejected at mid start bit
    @(posedge clk);
    n = acc0;
    rx0 = 1'b0;
    repeat (6) @(posedge clk);
    rx0 = 1'b1;
    repeat (64) @(posedge clk);
    @(negedge clk);
    chk("glitch_no_frame", 32'(acc0 - n), 32'd0);
    chk("glitch_valid", 32'(v0), 32'd0);

    // 0x3C with low stop bit, then 0x55 back-to-back
    @(posedge clk);
    n = acc0;
    send(0, 8'h3C, 8, -1, 1'b0, 1'b1, 1);
    chk("fe_count", 32'(acc0 - n), 32'd1);
    chk("fe_data", 32'(ld0), 32'h3C);
    chk("fe_flag", 32'(lfe0), 32'd1);
    send(0, 8'h55, 8, -1, 1'b1, 1'b1, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("b2b_count", 32'(acc0 - n), 32'd2);
    chk("b2b_data", 32'(ld0), 32'h55);
    chk("b2b_fe", 32'(lfe0), 32'd0);

    // Overrun: hold 0x11, drop 0x22
    @(posedge clk);
    r0 = 1'b0;
    n = ovc0;
    send(0, 8'h11, 8, -1, 1'b1, 1'b1, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("ovr_hold_valid", 32'(v0), 32'd1);
    chk("ovr_hold_data", 32'(d0), 32'h11);
    chk("ovr_none_yet", 32'(ovc0 - n), 32'd0);
    @(posedge clk);
    send(0, 8'h22, 8, -1, 1'b1, 1'b1, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("ovr_pulse_once", 32'(ovc0 - n), 32'd1);
    chk("ovr_data_kept", 32'(d0), 32'h11);
    chk("ovr_valid_kept", 32'(v0), 32'd1);
    m = acc0;
    r0 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ovr_valid_drop", 32'(v0), 32'd0);
    chk("ovr_data_retain", 32'(d0), 32'h11);
    chk("ovr_accept_once", 32'(acc0 - m), 32'd1);
    chk("ovr_accept_data", 32'(ld0), 32'h11);

    // Even parity on 0x07 (three ones -> parity bit must be 1)
    @(posedge clk);
    n = acc1;
    send(1, 8'h07, 8, 0, 1'b1, 1'b1, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("par_bad_count", 32'(acc1 - n), 32'd1);
    chk("par_bad_data", 32'(ld1), 32'h07);
    chk("par_bad_pe", 32'(lpe1), 32'd1);
    chk("par_bad_fe", 32'(lfe1), 32'd0);
    @(posedge clk);
    send(1, 8'h07, 8, 1, 1'b1, 1'b1, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("par_ok_count", 32'(acc1 - n), 32'd2);
    chk("par_ok_pe", 32'(lpe1), 32'd0);

    // 7N2, second stop bit low
    @(posedge clk);
    n = acc2;
    send(2, 8'h5A, 7, -1, 1'b1, 1'b0, 2);
    rx2 = 1'b1;
    repeat (64) @(posedge clk);
    @(negedge clk);
    chk("stop2_count", 32'(acc2 - n), 32'd1);
    chk("stop2_data", 32'(ld2), 32'h5A);
    chk("stop2_fe", 32'(lfe2), 32'd1);
    chk("stop2_pe", 32'(pe2), 32'd0);

    // Reset mid-data aborts the frame
    @(posedge clk);
    n = acc2;
    m = ovc2;
    bitx(2, 1'b0);
    bitx(2, 1'b0);
    bitx(2, 1'b1);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", 32'(v2), 32'd0);
    reset = 1'b1;
    rx2 = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_frame", 32'(acc2 - n), 32'd0);
    chk("midrst_no_ovr", 32'(ovc2 - m), 32'd0);
    @(posedge clk);
    send(2, 8'h01, 7, -1, 1'b1, 1'b1, 2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("post_rst_count", 32'(acc2 - n), 32'd1);
    chk("post_rst_data", 32'(ld2), 32'h01);
    chk("post_rst_fe", 32'(lfe2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame; legal range 5..8.
REQ-002 Parameter OVERSAMPLE, default 16, sample ticks per bit; legal values are even numbers from 8 to 32.
REQ-003 Parameter CLK_DIV, default 27, clk cycles per sample tick; minimum 1.
REQ-004 Parameter PARITY_EN, default 0, where 1 means one parity bit follows the data bits.
REQ-005 Parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity; ignored when PARITY_EN=0.
REQ-006 Parameter STOP_BITS, default 1, number of stop bits; legal values are 1 and 2.
REQ-007 clk  input  1  system clock; all logic is on the rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 rx  input  1  asynchronous serial line; idles high.
REQ-010 data_out  output  DATA_BITS  received data, LSB received first.
REQ-011 valid  output  1  data_out and the error flags hold a completed frame.
REQ-012 ready  input  1  consumer accepts the frame in any cycle where valid=1 and ready=1.
REQ-013 frame_err  output  1  a stop bit was sampled low; qualified by valid.
REQ-014 parity_err  output  1  parity mismatch; qualified by valid; always 0 when PARITY_EN=0.
REQ-015 overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer, reset value 1; all sampling SHALL use the second flop output.
REQ-017 A free-running divider SHALL assert an internal tick for 1 clk every CLK_DIV clks; the divider SHALL restart at 0 on each IDLE->START transition.
REQ-018 States: IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE: on synchronized rx=0, SHALL go to START and clear the tick counter.
REQ-020 START: after OVERSAMPLE/2 ticks (mid start bit), if rx=0, SHALL go to DATA; if rx=1, SHALL treat it as a glitch and return to IDLE with no output change.
REQ-021 DATA: SHALL sample rx every OVERSAMPLE ticks, shifting LSB first, and go to PARITY after DATA_BITS samples if PARITY_EN=1, otherwise to STOP.
REQ-022 PARITY: SHALL sample after OVERSAMPLE ticks; error if (XOR of data bits XOR sampled bit) != PARITY_ODD; then go to STOP.
REQ-023 STOP: SHALL sample STOP_BITS times at OVERSAMPLE-tick spacing; frame_err if any stop sample=0.
REQ-024 The frame SHALL complete on the clk of the last stop sample, and the FSM SHALL return to IDLE in that same cycle, so a back-to-back start bit is detected from half a bit in.
REQ-025 On frame completion with valid=0, or with valid=1 and ready=1 in the same cycle: SHALL load data_out, frame_err and parity_err, and set valid=1 on the next clk.
REQ-026 On frame completion with valid=1 and ready=0: SHALL drop the new frame, keep the held outputs unchanged, and pulse overrun for 1 clk.
REQ-027 valid=1 and ready=1 with no completion: SHALL clear valid on the next clk; data_out SHALL retain its last value.
REQ-028 valid SHALL remain high, with data_out and the flags stable, until accepted.
REQ-029 A framing error SHALL still deliver the frame, with frame_err=1; the FSM SHALL return to IDLE and, if rx stays low, re-detect a start.
REQ-030 ready SHALL have no effect while valid=0.

Reset
REQ-031 While reset=0, the FSM SHALL be in IDLE, all counters 0, synchronizer flops 1, data_out=0, valid=0, frame_err=0, parity_err=0, overrun=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no valid and no overrun; after release, the FSM SHALL wait for a fresh falling edge of the synchronized rx.

Verification
REQ-033 Defaults with CLK_DIV=2 (32 clk/bit): send 0xA5 with 1 stop bit, ready=1 -> one valid, data_out=0xA5, frame_err=0, parity_err=0.
REQ-034 PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 0 -> valid, parity_err=1; resend with parity bit 1 -> parity_err=0.
REQ-035 Low pulse on rx of 6 clk (less than half a bit) -> FSM returns to IDLE, no valid.
REQ-036 Send 0x3C with stop bit low -> valid, data_out=0x3C, frame_err=1; next frame 0x55 sent immediately is received correctly.
REQ-037 ready=0, send 0x11 then 0x22 -> data_out stays 0x11, overrun pulses 1 clk at completion of the 0x22 frame; ready=1 then valid drops.
REQ-038 STOP_BITS=2, DATA_BITS=7: send 0x5A with second stop bit low -> frame_err=1; reset pulsed mid-data -> no valid, and the next frame 0x01 is received correctly.
